stopwatch_lap_timer: RTL and testbench
======================================

// Module: stopwatch_lap_timer
// PURPOSE
//  Parametrised successor of the stopwatch top.
//  - Counts MM:SS up (stopwatch mode) or down (timer mode).
//  - Internal prescaler generates the seconds tick from clk.
//  - Lap FIFO captures split times.
//  - Sits between the debounced button/command logic and the display/readout logic.
// PARAMETERS
//  TICKS_PER_SEC  1    clk cycles per counted second (>=1)
//  MIN_WIDTH      8    width of minutes output
//  MAX_MIN        99   highest minutes value (< 2**MIN_WIDTH)
//  LAP_DEPTH      4    lap FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1          system clock
//  rst        in   1          sync reset, active-high
//  start      in   1          start/resume command (level sampled per clk)
//  stop       in   1          pause command
//  reset      in   1          sync clear command: counters, FIFO, flags -> IDLE
//  mode       in   1          0=count up, 1=count down; sampled only in IDLE
//  load       in   1          preset counters from load_min/load_sec (IDLE only)
//  load_min   in   MIN_WIDTH  preset minutes
//  load_sec   in   6          preset seconds
//  lap        in   1          capture current MM:SS into lap FIFO
//  lap_rd     in   1          pop lap FIFO head
//  minutes    out  MIN_WIDTH  current minutes
//  seconds    out  6          current seconds, 0..59
//  status     out  2          00 IDLE, 01 RUNNING, 10 PAUSED, 11 EXPIRED
//  done       out  1          1-cycle pulse on entering EXPIRED
//  lap_min    out  MIN_WIDTH  FIFO head minutes (first-word fall-through)
//  lap_sec    out  6          FIFO head seconds
//  lap_valid  out  1          FIFO not empty
//  lap_full   out  1          FIFO full
//  lap_ovf    out  1          sticky: a lap was dropped because the FIFO was full
// BEHAVIOUR
//  Interface
//  - One clock; reset is synchronous and active-high.
//  - All outputs register-driven; all reset to 0 (status=IDLE, FIFO empty).
//  Command priority: rst > reset > stop > start > load.
//  FSM
//  - IDLE -start-> RUNNING.
//  - RUNNING -stop-> PAUSED.
//  - PAUSED -start-> RUNNING.
//  - RUNNING(down) reaching 00:00 -> EXPIRED.
//  - Any state -reset-> IDLE with 00:00, FIFO emptied, lap_ovf=0, prescaler=0.
//  - EXPIRED ignores start/stop/load; only reset (or rst) leaves it.
//  - Down mode: start in IDLE with value 00:00 goes straight to EXPIRED and pulses done.
//  Prescaler
//  - Runs only in RUNNING, counting 0..TICKS_PER_SEC-1.
//  - Tick is asserted when the count equals TICKS_PER_SEC-1.
//  - Holds its value in PAUSED; cleared on IDLE->RUNNING.
//  - Start sampled at edge k: status=RUNNING after edge k; first count update after edge k+TICKS_PER_SEC.
//  Up count
//  - seconds 59->0 carries minutes+1.
//  - MAX_MIN:59 wraps to 00:00 and keeps running; no flag.
//  Down count
//  - seconds 0->59 borrows minutes-1.
//  - The tick that produces 00:00 also moves to EXPIRED in the same edge; done=1 for exactly that next cycle.
//  Load
//  - Honoured only in IDLE.
//  - load_sec>59 clamps to 59; load_min>MAX_MIN clamps to MAX_MIN.
//  - mode is latched on IDLE->RUNNING.
//  Lap FIFO
//  - lap is accepted in RUNNING/PAUSED only; stores current (post-edge-free) MM:SS, i.e. the value visible on the capture cycle.
//  - lap when full (and no simultaneous pop): entry dropped, lap_ovf set.
//  - lap and lap_rd together when full: pop and push both occur, count unchanged.
//  - lap_rd when empty is ignored.
//  - lap_min/lap_sec are 0 when empty.
// TESTING
//  1 TPS=1, up: start 1 cycle, run 61 cycles -> 01:01, status=01; stop -> value frozen, status=10.
//  2 TPS=4: start; after 8 cycles seconds=2; stop 3 cycles mid-second, resume -> next tick 4 cycles after original phase minus elapsed (no lost/extra count).
//  3 down: load 00:02, mode=1, start, TPS=1 -> 00:01, 00:00 with status=11 and done=1 one cycle; start ignored; reset -> 00:00, IDLE.
//  4 up wrap: load 99:59 (MAX_MIN=99), start -> after 1 tick 00:00, status=01.
//  5 laps, LAP_DEPTH=4: 5 lap pulses at distinct times -> lap_full=1, lap_ovf=1, 4 entries read back in order via lap_rd; lap_valid drops after 4th pop.
//  6 simultaneous: stop+start same cycle in RUNNING -> PAUSED; reset+lap -> FIFO empty; rst mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/stopwatch_lap_timer.sv
// MM:SS stopwatch / countdown timer with an internal seconds prescaler and a
// small first-word-fall-through FIFO that holds captured lap (split) times.
module stopwatch_lap_timer #(
  parameter int TICKS_PER_SEC = 1,
  parameter int MIN_WIDTH     = 8,
  parameter int MAX_MIN       = 99,
  parameter int LAP_DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 reset,
  input  logic                 mode,
  input  logic                 load,
  input  logic [MIN_WIDTH-1:0] load_min,
  input  logic [5:0]           load_sec,
  input  logic                 lap,
  input  logic                 lap_rd,
  output logic [MIN_WIDTH-1:0] minutes,
  output logic [5:0]           seconds,
  output logic [1:0]           status,
  output logic                 done,
  output logic [MIN_WIDTH-1:0] lap_min,
  output logic [5:0]           lap_sec,
  output logic                 lap_valid,
  output logic                 lap_full,
  output logic                 lap_ovf
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int AW = $clog2(LAP_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = MIN_WIDTH + 6;
  localparam logic [PW-1:0]        TPS_M1  = PW'(TICKS_PER_SEC - 1);
  localparam logic [MIN_WIDTH-1:0] MAX_M   = MIN_WIDTH'(MAX_MIN);
  localparam logic [CW-1:0]        DEPTH_C = CW'(LAP_DEPTH);

  // Encoding doubles as the status output, so status is the state register.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_EXPIRED = 2'b11
  } state_t;

  state_t                 state;
  logic                   mode_q;
  logic [PW-1:0]          presc;
  logic                   tick;
  logic [MIN_WIDTH-1:0]   min_nx;
  logic [5:0]             sec_nx;

  assign status = state;

  always_comb begin
    tick   = (presc == TPS_M1);
    min_nx = minutes;
    sec_nx = seconds;
    if (!mode_q) begin
      if (seconds == 6'd59) begin
        sec_nx = '0;
        min_nx = (minutes == MAX_M) ? '0 : minutes + 1'b1;
      end else begin
        sec_nx = seconds + 1'b1;
      end
    end else begin
      if (seconds == 6'd0) begin
        sec_nx = 6'd59;
        min_nx = minutes - 1'b1;
      end else begin
        sec_nx = seconds - 1'b1;
      end
    end
  end

  // The prescaler only advances on edges that begin and end in RUNNING, so a
  // pause/resume cycle neither loses nor adds prescaler counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mode_q  <= 1'b0;
      presc   <= '0;
      minutes <= '0;
      seconds <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (reset) begin
        state   <= ST_IDLE;
        mode_q  <= 1'b0;
        presc   <= '0;
        minutes <= '0;
        seconds <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (stop) begin
              state <= ST_IDLE;
            end else if (start) begin
              presc  <= '0;
              mode_q <= mode;
              if (mode && minutes == '0 && seconds == 6'd0) begin
                state <= ST_EXPIRED;
                done  <= 1'b1;
              end else begin
                state <= ST_RUNNING;
              end
            end else if (load) begin
              minutes <= (load_min > MAX_M) ? MAX_M : load_min;
              seconds <= (load_sec > 6'd59) ? 6'd59 : load_sec;
            end
          end
          ST_RUNNING: begin
            if (stop) begin
              state <= ST_PAUSED;
            end else begin
              presc <= tick ? '0 : presc + 1'b1;
              if (tick) begin
                minutes <= min_nx;
                seconds <= sec_nx;
                if (mode_q && min_nx == '0 && sec_nx == 6'd0) begin
                  state <= ST_EXPIRED;
                  done  <= 1'b1;
                end
              end
            end
          end
          ST_PAUSED: begin
            if (!stop && start) state <= ST_RUNNING;
          end
          ST_EXPIRED: begin
            state <= ST_EXPIRED;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Lap readout handshake: lap_valid means lap_min/lap_sec hold the oldest
  // entry; lap_rd in a cycle with lap_valid high pops it, otherwise ignored.
  logic [EW-1:0] mem [LAP_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr, rd_nx, wr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          lap_take, lap_push, lap_pop, lap_drop;
  logic [EW-1:0] cur_mmss, head_nx;

  always_comb begin
    cur_mmss = {minutes, seconds};
    lap_take = lap && (state == ST_RUNNING || state == ST_PAUSED);
    lap_pop  = lap_rd && (cnt != '0);
    lap_push = lap_take && ((cnt != DEPTH_C) || lap_pop);
    lap_drop = lap_take && !lap_push;
    rd_nx    = lap_pop  ? rd_ptr + 1'b1 : rd_ptr;
    wr_nx    = lap_push ? wr_ptr + 1'b1 : wr_ptr;
    unique case ({lap_push, lap_pop})
      2'b10:   cnt_nx = cnt + 1'b1;
      2'b01:   cnt_nx = cnt - 1'b1;
      default: cnt_nx = cnt;
    endcase
    // The new head may be the entry being written on this same edge.
    if (cnt_nx == '0) begin
      head_nx = '0;
    end else if (lap_push && wr_ptr == rd_nx) begin
      head_nx = cur_mmss;
    end else begin
      head_nx = mem[rd_nx];
    end
  end

  always_ff @(posedge clk) begin
    if (lap_push) mem[wr_ptr] <= cur_mmss;
  end

  always_ff @(posedge clk) begin
    if (rst || reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      lap_valid <= 1'b0;
      lap_full  <= 1'b0;
      lap_ovf   <= 1'b0;
      lap_min   <= '0;
      lap_sec   <= '0;
    end else begin
      rd_ptr    <= rd_nx;
      wr_ptr    <= wr_nx;
      cnt       <= cnt_nx;
      lap_valid <= (cnt_nx != '0);
      lap_full  <= (cnt_nx == DEPTH_C);
      if (lap_drop) lap_ovf <= 1'b1;
      {lap_min, lap_sec} <= head_nx;
    end
  end

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Directed bench for stopwatch_lap_timer: one instance at one tick per clock,
// a second at four ticks per second, both driven from the same inputs.
module tb_stopwatch_lap_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b0, start = 1'b0, stop = 1'b0, reset = 1'b0;
  logic       mode = 1'b0, load = 1'b0, lap = 1'b0, lap_rd = 1'b0;
  logic [7:0] load_min = '0;
  logic [5:0] load_sec = '0;

  logic [7:0] minutes, lap_min, minutes4, lap_min4;
  logic [5:0] seconds, lap_sec, seconds4, lap_sec4;
  logic [1:0] status, status4;
  logic       done, lap_valid, lap_full, lap_ovf;
  logic       done4, lap_valid4, lap_full4, lap_ovf4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stopwatch_lap_timer #(.TICKS_PER_SEC(1), .MIN_WIDTH(8), .MAX_MIN(99), .LAP_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .reset(reset), .mode(mode),
    .load(load), .load_min(load_min), .load_sec(load_sec), .lap(lap), .lap_rd(lap_rd),
    .minutes(minutes), .seconds(seconds), .status(status), .done(done),
    .lap_min(lap_min), .lap_sec(lap_sec), .lap_valid(lap_valid), .lap_full(lap_full),
    .lap_ovf(lap_ovf)
  );

  stopwatch_lap_timer #(.TICKS_PER_SEC(4), .MIN_WIDTH(8), .MAX_MIN(99), .LAP_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .reset(reset), .mode(mode),
    .load(load), .load_min(load_min), .load_sec(load_sec), .lap(lap), .lap_rd(lap_rd),
    .minutes(minutes4), .seconds(seconds4), .status(status4), .done(done4),
    .lap_min(lap_min4), .lap_sec(lap_sec4), .lap_valid(lap_valid4), .lap_full(lap_full4),
    .lap_ovf(lap_ovf4)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_min"},   32'(minutes),   0);
    chk({tag, "_sec"},   32'(seconds),   0);
    chk({tag, "_stat"},  32'(status),    0);
    chk({tag, "_done"},  32'(done),      0);
    chk({tag, "_lmin"},  32'(lap_min),   0);
    chk({tag, "_lsec"},  32'(lap_sec),   0);
    chk({tag, "_valid"}, 32'(lap_valid), 0);
    chk({tag, "_full"},  32'(lap_full),  0);
    chk({tag, "_ovf"},   32'(lap_ovf),   0);
  endtask

  initial begin
    logic [5:0] lap_exp [4];
    lap_exp[0] = 6'd2; lap_exp[1] = 6'd5; lap_exp[2] = 6'd8; lap_exp[3] = 6'd11;

    // Power-on reset
    rst = 1'b1;
    step(2);
    chk_all_zero("rst");
    chk("rst_stat4", 32'(status4), 0);
    rst = 1'b0;

    // 1: up count, 61 seconds then pause
    start = 1'b1; step(1); start = 1'b0;
    chk("t1_run_stat", 32'(status), 1);
    chk("t1_run_sec0", 32'(seconds), 0);
    step(61);
    chk("t1_min", 32'(minutes), 1);
    chk("t1_sec", 32'(seconds), 1);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("t1_stop_stat", 32'(status), 2);
    chk("t1_stop_sec", 32'(seconds), 1);
    step(3);
    chk("t1_frozen_sec", 32'(seconds), 1);
    chk("t1_frozen_min", 32'(minutes), 1);

    // 3: countdown from 00:02 to expiry
    reset = 1'b1; step(1); reset = 1'b0;
    chk("t3_clr_stat", 32'(status), 0);
    chk("t3_clr_min", 32'(minutes), 0);
    load = 1'b1; load_min = 8'd0; load_sec = 6'd2; step(1); load = 1'b0;
    chk("t3_load_sec", 32'(seconds), 2);
    mode = 1'b1; start = 1'b1; step(1); start = 1'b0; mode = 1'b0;
    chk("t3_start_stat", 32'(status), 1);
    step(1);
    chk("t3_sec1", 32'(seconds), 1);
    chk("t3_done_early", 32'(done), 0);
    step(1);
    chk("t3_sec0", 32'(seconds), 0);
    chk("t3_exp_stat", 32'(status), 3);
    chk("t3_done", 32'(done), 1);
    step(1);
    chk("t3_done_pulse", 32'(done), 0);
    start = 1'b1; step(1); start = 1'b0;
    chk("t3_start_ign", 32'(status), 3);
    reset = 1'b1; step(1); reset = 1'b0;
    chk("t3_reset_stat", 32'(status), 0);
    chk("t3_reset_sec", 32'(seconds), 0);

    // Down start at 00:00 expires immediately
    mode = 1'b1; start = 1'b1; step(1); start = 1'b0; mode = 1'b0;
    chk("z_stat", 32'(status), 3);
    chk("z_done", 32'(done), 1);
    reset = 1'b1; step(1); reset = 1'b0;

    // 4: load clamps to 99:59, then up-count wraps
    load = 1'b1; load_min = 8'd200; load_sec = 6'd63; step(1); load = 1'b0;
    chk("t4_clamp_min", 32'(minutes), 99);
    chk("t4_clamp_sec", 32'(seconds), 59);
    start = 1'b1; step(1); start = 1'b0;
    step(1);
    chk("t4_wrap_min", 32'(minutes), 0);
    chk("t4_wrap_sec", 32'(seconds), 0);
    chk("t4_wrap_stat", 32'(status), 1);
    step(1);
    chk("t4_after_sec", 32'(seconds), 1);

    // 5: five laps into a four-entry FIFO
    reset = 1'b1; step(1); reset = 1'b0;
    start = 1'b1; step(1); start = 1'b0;
    step(2);
    lap = 1'b1; step(1); lap = 1'b0;
    chk("t5_first_valid", 32'(lap_valid), 1);
    chk("t5_first_sec", 32'(lap_sec), 2);
    for (int i = 0; i < 4; i++) begin
      step(2);
      lap = 1'b1; step(1); lap = 1'b0;
    end
    chk("t5_full", 32'(lap_full), 1);
    chk("t5_ovf", 32'(lap_ovf), 1);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("t5_pause_sec", 32'(seconds), 15);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_valid%0d", i), 32'(lap_valid), 1);
      chk($sformatf("t5_sec%0d", i), 32'(lap_sec), 32'(lap_exp[i]));
      chk($sformatf("t5_min%0d", i), 32'(lap_min), 0);
      lap_rd = 1'b1; step(1); lap_rd = 1'b0;
    end
    chk("t5_empty", 32'(lap_valid), 0);
    chk("t5_empty_sec", 32'(lap_sec), 0);
    chk("t5_ovf_sticky", 32'(lap_ovf), 1);
    lap_rd = 1'b1; step(1); lap_rd = 1'b0;
    chk("t5_rd_empty", 32'(lap_valid), 0);

    // 6: simultaneous commands
    start = 1'b1; step(1);
    stop = 1'b1; step(1); start = 1'b0; stop = 1'b0;
    chk("t6_ss_stat", 32'(status), 2);
    chk("t6_ss_sec", 32'(seconds), 15);
    lap = 1'b1; step(1); lap = 1'b0;
    chk("t6_plap_sec", 32'(lap_sec), 15);
    reset = 1'b1; lap = 1'b1; step(1); reset = 1'b0; lap = 1'b0;
    chk("t6_rl_valid", 32'(lap_valid), 0);
    chk("t6_rl_ovf", 32'(lap_ovf), 0);
    chk("t6_rl_stat", 32'(status), 0);
    start = 1'b1; step(1); start = 1'b0;
    lap = 1'b1; step(1); lap = 1'b0;
    step(2);
    chk("t6_run_sec", 32'(seconds), 3);
    chk("t6_run_valid", 32'(lap_valid), 1);
    rst = 1'b1; step(1); rst = 1'b0;
    chk_all_zero("t6_rst");

    // 2: four clocks per second, pause mid-second and resume
    start = 1'b1; step(1); start = 1'b0;
    chk("t2_start_stat", 32'(status4), 1);
    step(7);
    chk("t2_sec1", 32'(seconds4), 1);
    step(1);
    chk("t2_sec2", 32'(seconds4), 2);
    step(2);
    stop = 1'b1; step(3); stop = 1'b0;
    chk("t2_pause_stat", 32'(status4), 2);
    chk("t2_pause_sec", 32'(seconds4), 2);
    start = 1'b1; step(1); start = 1'b0;
    chk("t2_resume_stat", 32'(status4), 1);
    step(1);
    chk("t2_no_early", 32'(seconds4), 2);
    step(1);
    chk("t2_tick", 32'(seconds4), 3);
    step(3);
    chk("t2_no_extra", 32'(seconds4), 3);
    step(1);
    chk("t2_next", 32'(seconds4), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
